multi16_arbiter: RTL
====================

Name: multi16_arbiter

Overview:
- Time-shares one multi16 twiddle multiplier between NREQ butterfly requesters in the FFT datapath.
- Arbitrates valid/ready requests round-robin and issues one multiply per cycle into the multiplier pipeline.
- Tracks the requester ID of every in-flight product through the multiplier latency.
- Returns each 17-bit product to the requester that issued it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 1, multi16 latency in clock edges, from operands presented to mul_result valid.
- IDW, 2, requester ID width; equals clog2(NREQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant; handshake occurs when req_valid[i] and req_ready[i] are high at a clock edge.
- req_a  in  NREQ*17  per-requester data operand; two's complement, sign bit plus Q8.8.
- req_b  in  NREQ*8  per-requester twiddle operand; two's complement.
- mul_a  out  17  operand to multi16.in_17bit; registered.
- mul_b  out  8  operand to multi16.in_8bit; registered.
- mul_result  in  17  multi16.out.
- rsp_valid  out  NREQ  one-cycle pulse, one-hot, on the owner of rsp_data.
- rsp_data  out  17  product; registered.
- busy  out  1  high while any product is in flight.

Behaviour:
- Reset (async, rst_n=0):
  - mul_a, mul_b, rsp_data = 0.
  - rsp_valid = 0, busy = 0, req_ready = 0.
  - Tag pipe cleared; RR pointer = 0.
  - Products in flight at reset are dropped, never delivered.
- Arbitration (combinational grant):
  - Scan req_valid starting at index ptr, wrapping modulo NREQ.
  - req_ready = one-hot of the first set bit; all zero if req_valid = 0.
  - req_ready never asserts without the matching req_valid.
- Pointer update: on a handshake by index g, ptr <= (g+1) mod NREQ. With no handshake, ptr holds.
- Throughput: one accept per cycle; no bubbles under continuous requests.
- Issue, at the accepting edge E0:
  - mul_a <= req_a[g], mul_b <= req_b[g].
  - Tag pipe stage 0 <= {1, g}.
  - With no accept, stage 0 <= {0, x} and mul_a/mul_b hold their last values (saves toggling).
- Tag pipe:
  - MUL_LAT+1 stages of {valid, id}, shifting every cycle; no stall.
  - The last stage aligns with the edge at which mul_result is valid for that issue.
- Response, at edge E0+MUL_LAT+1:
  - rsp_data <= mul_result.
  - rsp_valid <= onehot(id) if the last tag stage is valid, else 0.
  - Total latency: MUL_LAT+1 edges after the accepting edge (MUL_LAT=1 gives 2 edges).
  - rsp_data holds its value when rsp_valid = 0.
- No response back-pressure: requesters must accept rsp_valid in the cycle it is high.
- Arithmetic: no width change, rounding or saturation in this block. Products pass bit-exact from mul_result.
- busy = OR of all tag-pipe valid bits OR any rsp_valid.
- Boundary conditions:
  - req_valid dropped before grant: nothing issued; ptr unchanged.
  - A single requester streaming alone is granted every cycle.
  - All requesters valid: grant order ptr, ptr+1, ... wrapping.
  - One requester with multiple in-flight products receives them in issue order.
  - An id >= NREQ cannot occur; an assertion checks this.

Decomposition:
- Package fft_pkg holds:
  - DATA_W=17, TW_W=8.
  - tag_t struct {logic vld; logic [IDW-1:0] id}.
  - function rr_next(ptr, vec).
- Sub-module rr_pick (NREQ): combinational one-hot round-robin grant from (req_valid, ptr), plus the binary index.
- multi16 is instantiated at the top level alongside this block, not inside it.

Test Plan:
- Reset: assert rst_n=0 mid-stream with two products in flight → all outputs 0 immediately; after release no rsp_valid pulse ever appears for the dropped products.
- Single request, MUL_LAT=1: requester 2 sends req_a=17'h00100, req_b=8'h7F, accepted at edge 1 → mul_a=17'h00100, mul_b=8'h7F after edge 1; rsp_valid=4'b0100 for exactly one cycle after edge 3; rsp_data equals the reference multi16 output for those operands.
- Fairness: all four req_valid held high for 8 cycles from ptr=0 → grant sequence 0,1,2,3,0,1,2,3; each requester receives exactly 2 responses, in order.
- Routing under interleave: requesters 1 and 3 alternate with distinct operands (17'h00080/8'h40 and 17'h1FF00/8'hFF) → every rsp_valid one-hot matches its issuer; rsp_data matches the model product per tag.
- Back-to-back, single requester: requester 0 streams 6 operands on consecutive cycles → 6 consecutive rsp_valid=4'b0001 cycles with no gaps; busy deasserts one cycle after the last response.
- Idle gap: request withdrawn before its edge → no handshake, ptr unchanged, mul_a/mul_b hold, busy stays 0.

Source files
------------

// File: rtl/multi16_arbiter_pkg.sv
// Shared widths, in-flight tag type and round-robin scan helper for the multi16 arbiter.
package multi16_arbiter_pkg;

    localparam int unsigned DATA_W   = 17;
    localparam int unsigned TW_W     = 8;
    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned IDW_MAX  = 3;
    localparam int unsigned CNT_W    = IDW_MAX + 1;

    typedef struct packed {
        logic               vld;
        logic [IDW_MAX-1:0] id;
    } tag_t;

    // First set bit of vec scanning upward from ptr, wrapping modulo nreq.
    function automatic logic [IDW_MAX-1:0] rr_next(
        input logic [IDW_MAX-1:0]  ptr,
        input logic [NREQ_MAX-1:0] vec,
        input logic [CNT_W-1:0]    nreq
    );
        logic [IDW_MAX-1:0] win;
        logic               found;
        logic [CNT_W-1:0]   idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ_MAX; k++) begin
            idx = CNT_W'(ptr) + CNT_W'(k);
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            if (!found && (CNT_W'(k) < nreq) && vec[idx[IDW_MAX-1:0]]) begin
                win   = idx[IDW_MAX-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/multi16_arbiter_if.sv
// Requester, multiplier and response signals of the multi16 arbiter.
interface multi16_arbiter_if
    import multi16_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DATA_W-1:0] req_a;
    logic [NREQ*TW_W-1:0]   req_b;
    logic [DATA_W-1:0]      mul_a;
    logic [TW_W-1:0]        mul_b;
    logic [DATA_W-1:0]      mul_result;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b, mul_result,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_result,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/multi16_arbiter_rr_pick.sv
// Combinational round-robin grant: one-hot grant, its index and an any-request flag.
module multi16_arbiter_rr_pick
    import multi16_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant_c,
    output logic [IDW-1:0]  idx_c,
    output logic            any_c
);

    assign any_c   = |req_valid;
    assign idx_c   = IDW'(rr_next(IDW_MAX'(ptr), NREQ_MAX'(req_valid), CNT_W'(NREQ)));
    assign grant_c = any_c ? (NREQ'(1) << idx_c) : '0;

endmodule

// File: rtl/multi16_arbiter.sv
// Shares one multi16 multiplier among NREQ requesters; tags each issue and routes
// the product back to its issuer MUL_LAT+1 edges after acceptance.
module multi16_arbiter
    import multi16_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned IDW     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    multi16_arbiter_if.slave bus
);

    logic                 en_q;
    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       ptr_d;
    logic [NREQ-1:0]      grant_c;
    logic [IDW-1:0]       gnt_idx_c;
    logic                 any_c;
    logic                 hs_c;
    tag_t                 issue_c;
    tag_t [MUL_LAT:0]     tag_q;
    tag_t [MUL_LAT:0]     tag_d;
    logic [NREQ-1:0]      rsp_valid_d;
    logic                 busy_d;

    multi16_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_valid (bus.req_valid),
        .ptr       (ptr_q),
        .grant_c   (grant_c),
        .idx_c     (gnt_idx_c),
        .any_c     (any_c)
    );

    // Grants are held off for the first cycle out of reset so req_ready reads 0 in reset.
    assign bus.req_ready = en_q ? grant_c : '0;
    assign hs_c          = en_q & any_c;

    always_comb begin
        ptr_d       = ptr_q;
        issue_c     = '0;
        rsp_valid_d = '0;
        busy_d      = 1'b0;
        if (hs_c) begin
            ptr_d   = (gnt_idx_c == IDW'(NREQ - 1)) ? '0 : gnt_idx_c + 1'b1;
            issue_c = '{vld: 1'b1, id: IDW_MAX'(gnt_idx_c)};
        end
        tag_d = {tag_q[MUL_LAT-1:0], issue_c};
        if (tag_q[MUL_LAT].vld) begin
            rsp_valid_d = NREQ'(1) << tag_q[MUL_LAT].id;
        end
        busy_d = |rsp_valid_d;
        for (int unsigned s = 0; s <= MUL_LAT; s++) begin
            busy_d = busy_d | tag_d[s].vld;
        end
    end

    // Operands only move on an accept; rsp_data only moves on a delivered product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q          <= 1'b0;
            ptr_q         <= '0;
            tag_q         <= '0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.busy      <= 1'b0;
        end else begin
            en_q          <= 1'b1;
            ptr_q         <= ptr_d;
            tag_q         <= tag_d;
            bus.rsp_valid <= rsp_valid_d;
            bus.busy      <= busy_d;
            if (hs_c) begin
                bus.mul_a <= bus.req_a[gnt_idx_c*DATA_W +: DATA_W];
                bus.mul_b <= bus.req_b[gnt_idx_c*TW_W +: TW_W];
            end
            if (tag_q[MUL_LAT].vld) begin
                bus.rsp_data <= bus.mul_result;
            end
            assert (!tag_q[MUL_LAT].vld || (32'(tag_q[MUL_LAT].id) < NREQ));
        end
    end

endmodule
